pattern_sequencer: RTL

//   Parametrised record/playback sequencer for the iCE40 board.
//   - Records up to DEPTH operator-entered words from active-low switches on each Store press.
//   - Plays the recorded words back on display, advancing one step every STEP_TICKS clocks.
//   - Adds loop, one-shot, ping-pong and hold modes, a Clear input and status outputs.

---
 rtl/pattern_sequencer_pkg.sv | 23 ++
 rtl/pattern_sequencer_if.sv | 29 ++
 rtl/pattern_sequencer_button_sync.sv | 30 +++
 rtl/pattern_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pattern_sequencer_pkg.sv
// Shared constants and helpers for the record/playback pattern sequencer.
package pattern_sequencer_pkg;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Operator-side signals of the pattern sequencer: buttons, switches and status outputs.
interface pattern_sequencer_if
  import pattern_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DEPTH      = 6
);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic                  Store;
  logic                  Clear;
  logic [1:0]            Mode;
  logic [DATA_WIDTH-1:0] Sequence;
  logic [DATA_WIDTH-1:0] display;
  logic [CW-1:0]         length;
  logic                  full;
  logic                  playing;

  modport master (
    output Store, Clear, Mode, Sequence,
    input  display, length, full, playing
  );

  modport slave (
    input  Store, Clear, Mode, Sequence,
    output display, length, full, playing
  );

endinterface

// File: rtl/pattern_sequencer_button_sync.sv
// Two-flop synchroniser with a preset value plus one delayed copy for edge/change detection.
module pattern_sequencer_button_sync #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] prev_o
);

  logic [WIDTH-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign prev_o = prev_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Records operator-entered words and plays them back in loop, one-shot, ping-pong or hold mode.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 2,
  parameter int unsigned           DEPTH      = 6,
  parameter int unsigned           TICK_WIDTH = 24,
  parameter logic [TICK_WIDTH-1:0] STEP_TICKS = 24'd3
) (
  input logic               clock,
  input logic               Reset,
  pattern_sequencer_if.slave bus
);

  localparam int unsigned           CW        = clog2(DEPTH + 1);
  localparam logic [CW-1:0]         ONE       = CW'(1);
  localparam logic [CW-1:0]         DEPTH_CW  = CW'(DEPTH);
  localparam logic [TICK_WIDTH-1:0] TICK_ONE  = TICK_WIDTH'(1);
  localparam logic [TICK_WIDTH-1:0] TICK_LAST = STEP_TICKS - TICK_ONE;

  logic                  store_sync, store_prev, clear_sync, clear_prev;
  logic [1:0]            mode_sync, mode_prev;
  logic [DATA_WIDTH-1:0] seq_sync, seq_prev_unused;

  pattern_sequencer_button_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_store_sync (
    .clk_i(clock), .rst_ni(Reset), .d_i(bus.Store), .sync_o(store_sync), .prev_o(store_prev)
  );
  pattern_sequencer_button_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_clear_sync (
    .clk_i(clock), .rst_ni(Reset), .d_i(bus.Clear), .sync_o(clear_sync), .prev_o(clear_prev)
  );
  pattern_sequencer_button_sync #(.WIDTH(2), .RESET_VAL(2'b00)) u_mode_sync (
    .clk_i(clock), .rst_ni(Reset), .d_i(bus.Mode), .sync_o(mode_sync), .prev_o(mode_prev)
  );
  pattern_sequencer_button_sync #(.WIDTH(DATA_WIDTH), .RESET_VAL('1)) u_seq_sync (
    .clk_i(clock), .rst_ni(Reset), .d_i(bus.Sequence), .sync_o(seq_sync),
    .prev_o(seq_prev_unused)
  );

  logic store_press, clear_press, mode_change;
  assign store_press = store_prev & ~store_sync;
  assign clear_press = clear_prev & ~clear_sync;
  assign mode_change = (mode_prev != mode_sync);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         length_q, length_d, idx_q, idx_d;
  dir_e                  dir_q, dir_d;
  logic [TICK_WIDTH-1:0] div_q, div_d;
  logic                  full_q, full_d, we, last, tick;
  logic [DATA_WIDTH-1:0] display_q;

  assign last = (idx_q == length_q - ONE);
  assign tick = (div_q == TICK_LAST);

  always_comb begin
    length_d = length_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    div_d    = div_q;
    we       = 1'b0;
    // Clear beats a simultaneous store; a full store is dropped without touching playback.
    if (clear_press) begin
      length_d = '0;
      idx_d    = '0;
      dir_d    = DIR_UP;
      div_d    = '0;
    end else if (store_press && !full_q) begin
      we       = 1'b1;
      length_d = length_q + ONE;
      idx_d    = '0;
      dir_d    = DIR_UP;
      div_d    = '0;
    end else if (mode_change) begin
      idx_d = '0;
      dir_d = DIR_UP;
      div_d = '0;
    end else if ((length_q != '0) && (mode_sync != MODE_HOLD)) begin
      div_d = tick ? '0 : div_q + TICK_ONE;
      if (tick) begin
        unique case (mode_sync)
          MODE_LOOP:    idx_d = last ? '0 : idx_q + ONE;
          MODE_ONESHOT: idx_d = last ? idx_q : idx_q + ONE;
          MODE_PINGPONG: begin
            if (length_q == ONE) begin
              idx_d = '0;
            end else if (dir_q == DIR_UP) begin
              if (last) begin
                dir_d = DIR_DOWN;
                idx_d = idx_q - ONE;
              end else begin
                idx_d = idx_q + ONE;
              end
            end else if (idx_q == '0) begin
              dir_d = DIR_UP;
              idx_d = idx_q + ONE;
            end else begin
              idx_d = idx_q - ONE;
            end
          end
          MODE_HOLD: idx_d = idx_q;
        endcase
      end
    end
    full_d = (length_d == DEPTH_CW);
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      length_q  <= '0;
      idx_q     <= '0;
      dir_q     <= DIR_UP;
      div_q     <= '0;
      full_q    <= 1'b0;
      display_q <= '0;
    end else begin
      length_q  <= length_d;
      idx_q     <= idx_d;
      dir_q     <= dir_d;
      div_q     <= div_d;
      full_q    <= full_d;
      display_q <= (length_q == '0) ? '0 : mem[idx_q];
    end
  end

  // Recording storage is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (we) mem[length_q] <= ~seq_sync;
  end

  assign bus.display = display_q;
  assign bus.length  = length_q;
  assign bus.full    = full_q;
  assign bus.playing = (length_q != '0) && (mode_sync != MODE_HOLD) &&
                       !((mode_sync == MODE_ONESHOT) && last);

endmodule
